// File: rtl/alu_exec_ctrl_if.sv
// alu_exec_ctrl_if: instruction-issue and writeback handshake bundle for the
// execute-stage sequencer. The master side is decode/register-read plus the
// register-file write port; the slave side is alu_exec_ctrl.
interface alu_exec_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inf;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_rd;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [3:0]  wb_rd;
    logic        wb_we;

    modport master (
        output in_valid, in_inf, in_a, in_b, in_rd, wb_ready,
        input  in_ready, wb_valid, wb_data, wb_rd, wb_we
    );

    modport slave (
        input  in_valid, in_inf, in_a, in_b, in_rd, wb_ready,
        output in_ready, wb_valid, wb_data, wb_rd, wb_we
    );
endinterface

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: execute-stage sequencer around a shared combinational ALU.
// Accepts one instruction at a time, registers the ALU operands, owns the
// architectural NZCV register, evaluates the condition field, stretches
// multiply to MUL_CYCLES ALU cycles and presents a registered writeback.
// Optional feature macro: ALU_CTRL_OVERLAP_EN -- when defined, a retirement
// in WB and a new accept may share one clock edge (one instruction / 2 cycles).
module alu_exec_ctrl #(
    parameter int MUL_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_exec_ctrl_if.slave   bus,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [31:0]      alu_inf,
    input  logic [31:0]      alu_r,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic             alu_c,
    input  logic             alu_v,
    output logic [3:0]       flags,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, EXEC, MUL_WAIT, WB} state_t;

    localparam logic [3:0] OP_MUL      = 4'b0010;
    localparam logic [3:0] OP_CMP      = 4'b0110;
    localparam logic [3:0] MUL_LOAD    = 4'(MUL_CYCLES - 1);
    localparam logic       MUL_STRETCH = (MUL_CYCLES > 1);

    state_t     state;
    logic [3:0] cnt;
    logic       pass;
    logic       idle_rdy;
    logic [3:0] rd_q;
    logic       accept;
    logic       in_mul;
    logic [3:0] op;
    logic       flag_upd;

    // Condition field evaluated against {N,Z,C,V}.
    function automatic logic cond_pass(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = !z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = !c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = !n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = !v;
            4'b1000: cond_pass = c && !z;
            4'b1001: cond_pass = !c || z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = !z && (n == v);
            4'b1101: cond_pass = z || (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    // Opcodes that produce a register result.
    function automatic logic op_writes(input logic [3:0] o);
        op_writes = (o <= 4'b0101) || (o == 4'b0111) || (o == 4'b1000);
    endfunction

    // Opcodes 1001-1111 are undefined and never touch the flags.
    function automatic logic op_defined(input logic [3:0] o);
        op_defined = (o <= 4'b1000);
    endfunction

    // Ready is registered in IDLE; with overlap, WB forwards the consumer's ready.
`ifdef ALU_CTRL_OVERLAP_EN
    assign bus.in_ready = idle_rdy || ((state == WB) && bus.wb_ready);
`else
    assign bus.in_ready = idle_rdy;
`endif

    // Accept decode and flag-update qualification for the EXEC cycle.
    assign accept   = bus.in_valid && bus.in_ready;
    assign in_mul   = (bus.in_inf[27:24] == OP_MUL) && MUL_STRETCH;
    assign op       = alu_inf[27:24];
    assign flag_upd = pass && op_defined(op) && (alu_inf[23] || (op == OP_CMP));

    // Sequencer: issue, multiply stretch, result capture and writeback hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            pass         <= 1'b0;
            idle_rdy     <= 1'b0;
            busy         <= 1'b0;
            flags        <= '0;
            rd_q         <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_inf      <= '0;
            bus.wb_valid <= 1'b0;
            bus.wb_data  <= '0;
            bus.wb_rd    <= '0;
            bus.wb_we    <= 1'b0;
        end else if (accept) begin
            // Condition field forced to AL so the ALU's own check always passes.
            alu_a        <= bus.in_a;
            alu_b        <= bus.in_b;
            alu_inf      <= {4'b1110, bus.in_inf[27:0]};
            rd_q         <= bus.in_rd;
            pass         <= cond_pass(bus.in_inf[31:28], flags);
            idle_rdy     <= 1'b0;
            busy         <= 1'b1;
            bus.wb_valid <= 1'b0;
            if (in_mul) begin
                state <= MUL_WAIT;
                cnt   <= MUL_LOAD;
            end else begin
                state <= EXEC;
            end
        end else begin
            case (state)
                IDLE: idle_rdy <= 1'b1;
                MUL_WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= EXEC;
                end
                EXEC: begin
                    bus.wb_data  <= alu_r;
                    bus.wb_rd    <= rd_q;
                    bus.wb_we    <= pass && op_writes(op);
                    bus.wb_valid <= 1'b1;
                    if (flag_upd) flags <= {alu_n, alu_z, alu_c, alu_v};
                    state <= WB;
                end
                WB: begin
                    if (bus.wb_ready) begin
                        bus.wb_valid <= 1'b0;
                        idle_rdy     <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: randomized self-checking bench for alu_exec_ctrl with a
// behavioural ALU stand-in and an instruction-level reference model.
module tb_alu_exec_ctrl;
    localparam int MULC = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] alu_a, alu_b, alu_inf, alu_r;
    logic        alu_n, alu_z, alu_c, alu_v;
    logic [3:0]  flags;
    logic        busy;
    logic [3:0]  mflags;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;

    alu_exec_ctrl_if bus();

    alu_exec_ctrl #(.MUL_CYCLES(MULC)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .alu_a(alu_a), .alu_b(alu_b), .alu_inf(alu_inf), .alu_r(alu_r),
        .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .flags(flags), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: returns {N,Z,C,V,result}.
    function automatic logic [35:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic c, v;
        r = '0; c = 1'b0; v = 1'b0;
        case (op)
            4'd0: begin {c, r} = {1'b0, a} + {1'b0, b}; v = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd1, 4'd6: begin r = a - b; c = (a >= b); v = (a[31] != b[31]) && (r[31] != a[31]); end
            4'd2: r = a * b;
            4'd3: r = a & b;
            4'd4: r = a | b;
            4'd5: r = a ^ b;
            4'd7: r = b;
            4'd8: r = a & ~b;
            default: r = ~a;
        endcase
        return {r[31], (r == 32'd0), c, v, r};
    endfunction

    always_comb {alu_n, alu_z, alu_c, alu_v, alu_r} = ref_alu(alu_inf[27:24], alu_a, alu_b);

    // Condition codes as base predicate on cc[3:1], inverted by cc[0].
    function automatic logic ref_cond(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v, base;
        {n, z, c, v} = f;
        case (cc[3:1])
            3'd0: base = z;
            3'd1: base = c;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = c && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (cc == 4'hF) return 1'b0;
        return cc[0] ? !base : base;
    endfunction

    // Instruction-level model: expected result, write enable, latency; updates mflags.
    task automatic model(input logic [31:0] inf, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] ed, output logic ewe, output int elat);
        logic [35:0] res;
        logic [3:0]  op;
        logic        ok;
        op   = inf[27:24];
        res  = ref_alu(op, a, b);
        ok   = ref_cond(inf[31:28], mflags);
        ed   = res[31:0];
        ewe  = ok && (op inside {[4'd0:4'd5], 4'd7, 4'd8});
        if (ok && (op <= 4'd8) && (inf[23] || op == 4'd6)) mflags = res[35:32];
        elat = (op == 4'd2 && MULC > 1) ? MULC + 1 : 2;
    endtask

    // Issue one instruction with wb_ready high and observe its writeback.
    task automatic do_instr(input logic [31:0] inf, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] rd, output int lat, output logic [31:0] d,
                            output logic we, output logic [3:0] rdo, output logic [3:0] fl,
                            output logic busy_ok, output logic [31:0] oinf);
        int w;
        lat = -1; d = '0; we = 1'b0; rdo = '0; fl = '0; busy_ok = 1'b1; oinf = '0;
        w = 0;
        while (!bus.in_ready && w < 50) begin @(posedge clk); #1; w++; end
        if (!bus.in_ready) return;
        bus.in_valid = 1'b1; bus.in_inf = inf; bus.in_a = a; bus.in_b = b; bus.in_rd = rd;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        oinf = alu_inf;
        w = 0;
        while (!bus.wb_valid && w < 50) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1; w++;
        end
        if (!bus.wb_valid) return;
        lat = w + 1;
        d = bus.wb_data; we = bus.wb_we; rdo = bus.wb_rd; fl = flags;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
        n_vec++; if (bus.wb_valid !== 1'b0) begin n_err++; $display("FAIL rst_wb_valid: got %b want 0", bus.wb_valid); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_vec++; if (flags !== 4'h0) begin n_err++; $display("FAIL rst_flags: got %h want 0", flags); end
        n_vec++; if ({alu_a, alu_b, alu_inf, bus.wb_data, bus.wb_rd, bus.wb_we} !== '0)
            begin n_err++; $display("FAIL rst_outputs: got %h/%h/%h/%h want all 0", alu_a, alu_b, alu_inf, bus.wb_data); end
        mflags = 4'h0;
        rst_n = 1'b1;
        n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready_early: got %b want 0", bus.in_ready); end
        @(posedge clk); #1;
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready_rise: got %b want 1", bus.in_ready); end
    endtask

    task automatic test_adds();
        logic [31:0] ed, d, oinf; logic ewe, we, bok; logic [3:0] rdo, fl; int elat, lat;
        model(32'hE080_0000, 32'd5, 32'd7, ed, ewe, elat);
        do_instr(32'hE080_0000, 32'd5, 32'd7, 4'd3, lat, d, we, rdo, fl, bok, oinf);
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL adds_latency: got %0d want 2", lat); end
        n_vec++; if (d !== 32'd12) begin n_err++; $display("FAIL adds_data: got %0d want 12", d); end
        n_vec++; if (we !== 1'b1) begin n_err++; $display("FAIL adds_we: got %b want 1", we); end
        n_vec++; if (rdo !== 4'd3) begin n_err++; $display("FAIL adds_rd: got %0d want 3", rdo); end
        n_vec++; if (fl !== 4'h0) begin n_err++; $display("FAIL adds_flags: got %h want 0", fl); end
        n_vec++; if (oinf !== 32'hE080_0000) begin n_err++; $display("FAIL adds_alu_inf: got %h want E0800000", oinf); end
    endtask

    task automatic test_cond();
        logic [31:0] ed, d, oinf; logic ewe, we, bok; logic [3:0] rdo, fl; int elat, lat;
        model(32'hE600_0000, 32'd3, 32'd3, ed, ewe, elat);
        do_instr(32'hE600_0000, 32'd3, 32'd3, 4'd1, lat, d, we, rdo, fl, bok, oinf);
        n_vec++; if (we !== 1'b0) begin n_err++; $display("FAIL cmp_we: got %b want 0", we); end
        n_vec++; if (fl[2] !== 1'b1 || fl !== mflags) begin n_err++; $display("FAIL cmp_flags: got %h want %h", fl, mflags); end
        model(32'h0000_0000, 32'd1, 32'd1, ed, ewe, elat);
        do_instr(32'h0000_0000, 32'd1, 32'd1, 4'd2, lat, d, we, rdo, fl, bok, oinf);
        n_vec++; if (d !== 32'd2) begin n_err++; $display("FAIL addeq_data: got %0d want 2", d); end
        n_vec++; if (we !== 1'b1) begin n_err++; $display("FAIL addeq_we: got %b want 1", we); end
        n_vec++; if (oinf[31:28] !== 4'hE) begin n_err++; $display("FAIL addeq_forced_cond: got %h want e", oinf[31:28]); end
        model(32'h1000_0000, 32'd1, 32'd1, ed, ewe, elat);
        do_instr(32'h1000_0000, 32'd1, 32'd1, 4'd2, lat, d, we, rdo, fl, bok, oinf);
        n_vec++; if (we !== 1'b0) begin n_err++; $display("FAIL addne_we: got %b want 0", we); end
        n_vec++; if (fl !== mflags) begin n_err++; $display("FAIL addne_flags: got %h want %h", fl, mflags); end
    endtask

    task automatic test_mul();
        logic [31:0] ed, d, oinf; logic ewe, we, bok; logic [3:0] rdo, fl; int elat, lat;
        model(32'hE200_0000, 32'd6, 32'd7, ed, ewe, elat);
        do_instr(32'hE200_0000, 32'd6, 32'd7, 4'd5, lat, d, we, rdo, fl, bok, oinf);
        n_vec++; if (lat !== MULC + 1) begin n_err++; $display("FAIL mul_latency: got %0d want %0d", lat, MULC + 1); end
        n_vec++; if (d !== 32'd42) begin n_err++; $display("FAIL mul_data: got %0d want 42", d); end
        n_vec++; if (bok !== 1'b1) begin n_err++; $display("FAIL mul_busy: got %b want 1", bok); end
        n_vec++; if (we !== ewe) begin n_err++; $display("FAIL mul_we: got %b want %b", we, ewe); end
    endtask

    task automatic test_backpressure();
        logic [31:0] ed, d0; logic ewe, we0, bad; logic [3:0] rd0; int elat, w;
        model(32'hE000_0000, 32'd100, 32'd23, ed, ewe, elat);
        bus.wb_ready = 1'b0;
        w = 0;
        while (!bus.in_ready && w < 50) begin @(posedge clk); #1; w++; end
        bus.in_valid = 1'b1; bus.in_inf = 32'hE000_0000; bus.in_a = 32'd100; bus.in_b = 32'd23; bus.in_rd = 4'd9;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        w = 0;
        while (!bus.wb_valid && w < 50) begin @(posedge clk); #1; w++; end
        d0 = bus.wb_data; we0 = bus.wb_we; rd0 = bus.wb_rd;
        n_vec++; if (d0 !== ed || rd0 !== 4'd9 || we0 !== ewe)
            begin n_err++; $display("FAIL bp_record: got %0d/%0d/%b want %0d/9/%b", d0, rd0, we0, ed, ewe); end
        bad = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (bus.wb_valid !== 1'b1 || bus.wb_data !== d0 || bus.wb_rd !== rd0 ||
                bus.wb_we !== we0 || bus.in_ready !== 1'b0) bad = 1'b1;
        end
        n_vec++; if (bad !== 1'b0) begin n_err++; $display("FAIL bp_hold: got unstable=%b want 0", bad); end
        bus.wb_ready = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (bus.wb_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1)
            begin n_err++; $display("FAIL bp_release: got v=%b busy=%b rdy=%b want 0/0/1", bus.wb_valid, busy, bus.in_ready); end
    endtask

    task automatic test_undef();
        logic [31:0] ed, d, oinf; logic ewe, we, bok; logic [3:0] rdo, fl; int elat, lat;
        model(32'hE600_0000, 32'd1, 32'd2, ed, ewe, elat);
        do_instr(32'hE600_0000, 32'd1, 32'd2, 4'd0, lat, d, we, rdo, fl, bok, oinf);
        n_vec++; if (fl !== 4'b1000) begin n_err++; $display("FAIL undef_setup_flags: got %h want 8", fl); end
        model(32'hEB80_0000, 32'd0, 32'd0, ed, ewe, elat);
        do_instr(32'hEB80_0000, 32'd0, 32'd0, 4'd4, lat, d, we, rdo, fl, bok, oinf);
        n_vec++; if (we !== 1'b0) begin n_err++; $display("FAIL undef_we: got %b want 0", we); end
        n_vec++; if (fl !== 4'b1000) begin n_err++; $display("FAIL undef_flags: got %h want 8", fl); end
        model(32'hF080_0000, 32'd0, 32'd0, ed, ewe, elat);
        do_instr(32'hF080_0000, 32'd0, 32'd0, 4'd4, lat, d, we, rdo, fl, bok, oinf);
        n_vec++; if (we !== 1'b0) begin n_err++; $display("FAIL never_we: got %b want 0", we); end
        n_vec++; if (fl !== 4'b1000) begin n_err++; $display("FAIL never_flags: got %h want 8", fl); end
    endtask

    task automatic test_reset_mid();
        logic seen; int w;
        w = 0;
        while (!bus.in_ready && w < 50) begin @(posedge clk); #1; w++; end
        bus.in_valid = 1'b1; bus.in_inf = 32'hE280_0000; bus.in_a = 32'd9; bus.in_b = 32'd9; bus.in_rd = 4'd7;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        mflags = 4'h0;
        n_vec++; if (flags !== mflags) begin n_err++; $display("FAIL rmid_flags: got %h want 0", flags); end
        n_vec++; if (bus.wb_valid !== 1'b0 || bus.in_ready !== 1'b0 || busy !== 1'b0)
            begin n_err++; $display("FAIL rmid_ctrl: got v=%b rdy=%b busy=%b want 0/0/0", bus.wb_valid, bus.in_ready, busy); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rmid_ready: got %b want 1", bus.in_ready); end
        seen = 1'b0;
        repeat (8) begin @(posedge clk); #1; if (bus.wb_valid !== 1'b0) seen = 1'b1; end
        n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL rmid_no_wb: got %b want 0", seen); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e1, e2, d1, d2, v; logic ew1, ew2, we1, we2, got1; int el, w, t1, t2, per;
`ifdef ALU_CTRL_OVERLAP_EN
        per = 2;
`else
        per = 3;
`endif
        v = $urandom;
        model(32'hE600_0000, v, v, e1, ew1, el);
        model(32'h0000_0000, v, 32'd5, e2, ew2, el);
        w = 0;
        while (!bus.in_ready && w < 50) begin @(posedge clk); #1; w++; end
        bus.in_valid = 1'b1; bus.in_inf = 32'hE600_0000; bus.in_a = v; bus.in_b = v; bus.in_rd = 4'd1;
        @(posedge clk); #1;
        t1 = cyc;
        bus.in_inf = 32'h0000_0000; bus.in_a = v; bus.in_b = 32'd5; bus.in_rd = 4'd2;
        got1 = 1'b0; d1 = '0; we1 = 1'b1; w = 0;
        while (!bus.in_ready && w < 50) begin
            if (bus.wb_valid && !got1) begin d1 = bus.wb_data; we1 = bus.wb_we; got1 = 1'b1; end
            @(posedge clk); #1; w++;
        end
        if (bus.wb_valid && !got1) begin d1 = bus.wb_data; we1 = bus.wb_we; got1 = 1'b1; end
        @(posedge clk); #1;
        t2 = cyc;
        bus.in_valid = 1'b0;
        w = 0;
        while (!bus.wb_valid && w < 50) begin @(posedge clk); #1; w++; end
        d2 = bus.wb_data; we2 = bus.wb_we;
        @(posedge clk); #1;
        n_vec++; if (t2 - t1 !== per) begin n_err++; $display("FAIL b2b_period: got %0d want %0d", t2 - t1, per); end
        n_vec++; if (d1 !== e1 || we1 !== ew1) begin n_err++; $display("FAIL b2b_first: got %h/%b want %h/%b", d1, we1, e1, ew1); end
        n_vec++; if (d2 !== e2 || we2 !== ew2) begin n_err++; $display("FAIL b2b_second: got %h/%b want %h/%b", d2, we2, e2, ew2); end
        n_vec++; if (flags !== mflags) begin n_err++; $display("FAIL b2b_flags: got %h want %h", flags, mflags); end
    endtask

    task automatic test_random();
        logic [31:0] inf, a, b, ed, d, oinf; logic ewe, we, bok; logic [3:0] rd, rdo, fl; int elat, lat;
        for (int i = 0; i < 40; i++) begin
            inf = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 23'($urandom)};
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            rd = 4'($urandom_range(0, 15));
            model(inf, a, b, ed, ewe, elat);
            do_instr(inf, a, b, rd, lat, d, we, rdo, fl, bok, oinf);
            n_vec++; if (lat !== elat) begin n_err++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, elat); end
            n_vec++; if (d !== ed) begin n_err++; $display("FAIL rnd%0d_data: got %h want %h", i, d, ed); end
            n_vec++; if (we !== ewe) begin n_err++; $display("FAIL rnd%0d_we: got %b want %b", i, we, ewe); end
            n_vec++; if (rdo !== rd) begin n_err++; $display("FAIL rnd%0d_rd: got %0d want %0d", i, rdo, rd); end
            n_vec++; if (fl !== mflags) begin n_err++; $display("FAIL rnd%0d_flags: got %h want %h", i, fl, mflags); end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_inf = '0; bus.in_a = '0; bus.in_b = '0; bus.in_rd = '0;
        bus.wb_ready = 1'b1;
        mflags = 4'h0;
        test_reset();
        test_adds();
        test_cond();
        test_mul();
        test_backpressure();
        test_undef();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
